// File: rtl/l2data_array_mw.sv
// rtl/l2data_array_mw.sv - multi-way L2 data array with byte-masked writes and a sequential clear walk
//
// Purpose:
//   This is a num_ways x num_sets array of s_line-bit lines, held in flops.
//   After reset, or on a clear request, a walk zeroes one set per cycle
//   across all ways. Reads and writes are accepted only in IDLE. A read
//   returns the line one cycle later, and same-line write bytes are
//   forwarded into that read result.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   clear      - request a full-array zeroing walk (ignored while walking)
//   ready      - high in IDLE; reads/writes are accepted only then
//   read       - read request for (rway, rindex)
//   rway       - read way
//   rindex     - read set
//   write_en   - per-byte write mask, bit i covers datain[8*i +: 8]
//   wway       - write way
//   windex     - write set
//   datain     - write data
//   dataout    - registered read data, held between reads
//   dout_valid - one-cycle pulse when dataout carries a new read result

module l2data_array_mw #(
  parameter int s_offset = 5,
  parameter int s_index  = 4,
  parameter int num_ways = 4,
  localparam int s_mask  = 2**s_offset,
  localparam int s_line  = 8*s_mask,
  localparam int s_way   = $clog2(num_ways)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  output logic              ready,
  input  logic              read,
  input  logic [s_way-1:0]  rway,
  input  logic [s_index-1:0] rindex,
  input  logic [s_mask-1:0] write_en,
  input  logic [s_way-1:0]  wway,
  input  logic [s_index-1:0] windex,
  input  logic [s_line-1:0] datain,
  output logic [s_line-1:0] dataout,
  output logic              dout_valid
);

  localparam int num_sets = 2**s_index;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state;
  logic [s_index-1:0]  counter;
  logic [s_line-1:0]   mem [num_ways][num_sets];
  logic [s_line-1:0]   rd_line;

  assign ready = (state == IDLE);

  // Read data with same-line write bypass. When the write targets a different
  // line, the stored line is returned unchanged. dataout loads this value
  // only on an accepted read.
  always_comb begin
    rd_line = mem[rway][rindex];
    if (rway == wway && rindex == windex) begin
      for (int i = 0; i < s_mask; i++) begin
        if (write_en[i]) rd_line[8*i +: 8] = datain[8*i +: 8];
      end
    end
  end

  // Control FSM and registered read port
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      counter    <= '0;
      dataout    <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      case (state)
        CLEAR: begin
          // The counter wraps to 0 on the same edge that clears the last set.
          counter <= counter + 1'b1;
          if (counter == '1) state <= IDLE;
        end
        IDLE: begin
          if (read) begin
            dataout    <= rd_line;
            dout_valid <= 1'b1;
          end
          if (clear) begin
            state   <= CLEAR;
            counter <= '0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Array storage. Reset does not touch the contents; the walk that follows
  // reset zeroes them. Writes are blocked outside IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        for (int w = 0; w < num_ways; w++) begin
          mem[w][counter] <= '0;
        end
      end else begin
        for (int i = 0; i < s_mask; i++) begin
          if (write_en[i]) mem[wway][windex][8*i +: 8] <= datain[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_l2data_array_mw.sv
// tb/tb_l2data_array_mw.sv - self-checking bench for l2data_array_mw
module tb_l2data_array_mw;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clear = 1'b0;
  logic         read = 1'b0;
  logic [1:0]   rway = '0, wway = '0;
  logic [3:0]   rindex = '0, windex = '0;
  logic [31:0]  write_en = '0;
  logic [255:0] datain = '0;
  logic         ready, dout_valid;
  logic [255:0] dataout;

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  l2data_array_mw dut (
    .clk(clk), .rst(rst), .clear(clear), .ready(ready),
    .read(read), .rway(rway), .rindex(rindex),
    .write_en(write_en), .wway(wway), .windex(windex), .datain(datain),
    .dataout(dataout), .dout_valid(dout_valid)
  );

  // Behavioural model. It tracks only how many edges remain before the array
  // is usable, and the array contents. Once the walk finishes, the whole array
  // reads as zero. A write is applied before the read, so a same-line read
  // returns the merged line and any other line is unaffected.
  logic [255:0] m [4][16];
  logic [255:0] mk;
  int           busy = 16;
  logic         exp_ready = 1'b0, exp_valid = 1'b0;
  logic [255:0] exp_dout = '0;

  function automatic logic [255:0] bytes_mask(input logic [31:0] we);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = {8{we[i]}};
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      busy = 16;
      exp_valid = 1'b0;
      exp_dout = '0;
    end else if (busy > 0) begin
      exp_valid = 1'b0;
      busy = busy - 1;
      if (busy == 0)
        for (int w = 0; w < 4; w++)
          for (int s = 0; s < 16; s++) m[w][s] = '0;
    end else begin
      mk = bytes_mask(write_en);
      m[wway][windex] = (m[wway][windex] & ~mk) | (datain & mk);
      exp_valid = read;
      if (read) exp_dout = m[rway][rindex];
      if (clear) busy = 16;
    end
    exp_ready = (busy == 0);
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (checking) begin
      chk("model ready", {255'd0, ready}, {255'd0, exp_ready});
      chk("model dout_valid", {255'd0, dout_valid}, {255'd0, exp_valid});
      chk("model dataout", dataout, exp_dout);
    end
  end

  task automatic wr(input int w, input int s, input logic [31:0] we, input logic [255:0] d);
    wway = 2'(w); windex = 4'(s); write_en = we; datain = d;
    @(negedge clk);
    write_en = '0;
  endtask

  task automatic rd(input string nm, input int w, input int s, input logic [255:0] exp);
    read = 1'b1; rway = 2'(w); rindex = 4'(s);
    @(negedge clk);
    read = 1'b0;
    chk({nm, " valid"}, {255'd0, dout_valid}, 256'd1);
    chk(nm, dataout, exp);
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 256'(n), 256'd16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    checking = 1'b1;
    chk("reset ready", {255'd0, ready}, 256'd0);
    chk("reset dout_valid", {255'd0, dout_valid}, 256'd0);
    chk("reset dataout", dataout, 256'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_ready("ready after reset");
    rd("read 3,15 zero", 3, 15, 256'd0);

    // Partial write then read back
    wr(1, 5, 32'h0000000F, 256'hAAAAAAAA);
    rd("read 1,5 partial", 1, 5, 256'hAAAAAAAA);

    // Same-line read during write: byte 0 forwarded
    wr(2, 7, 32'hFFFFFFFF, {32{8'h11}});
    read = 1'b1; rway = 2'd2; rindex = 4'd7;
    wway = 2'd2; windex = 4'd7; write_en = 32'h1; datain = 256'h55;
    @(negedge clk);
    read = 1'b0; write_en = '0;
    chk("bypass valid", {255'd0, dout_valid}, 256'd1);
    chk("bypass data", dataout, {{31{8'h11}}, 8'h55});
    rd("stored after bypass", 2, 7, {{31{8'h11}}, 8'h55});

    // Different-way write in the same cycle does not affect the read
    read = 1'b1; rway = 2'd2; rindex = 4'd7;
    wway = 2'd0; windex = 4'd7; write_en = 32'hFFFFFFFF; datain = {32{8'h77}};
    @(negedge clk);
    read = 1'b0; write_en = '0;
    chk("other way read", dataout, {{31{8'h11}}, 8'h55});
    rd("other way stored", 0, 7, {32{8'h77}});

    // Back-to-back reads
    read = 1'b1; rway = 2'd1; rindex = 4'd5;
    @(negedge clk);
    chk("b2b first", dataout, 256'hAAAAAAAA);
    rway = 2'd0; rindex = 4'd7;
    @(negedge clk);
    read = 1'b0;
    chk("b2b second valid", {255'd0, dout_valid}, 256'd1);
    chk("b2b second", dataout, {32{8'h77}});

    // Clear walk: same-cycle read still performed, reads during the walk ignored,
    // and a clear pulse mid-walk does not restart it
    clear = 1'b1; read = 1'b1; rway = 2'd2; rindex = 4'd7;
    @(negedge clk);
    clear = 1'b0;
    chk("clear-cycle read", dataout, {{31{8'h11}}, 8'h55});
    begin
      int n = 0;
      while (!ready && n < 40) begin
        if (n == 5) clear = 1'b1; else clear = 1'b0;
        @(negedge clk);
        n++;
        chk("walk no valid", {255'd0, dout_valid}, 256'd0);
      end
      read = 1'b0; clear = 1'b0;
      chk("clear walk length", 256'(n), 256'd16);
    end
    for (int w = 0; w < 4; w++)
      for (int s = 0; s < 16; s++) rd("zero after clear", w, s, 256'd0);

    // Reset in the middle of a walk at counter 8
    wr(3, 3, 32'hFFFF0000, {32{8'hC3}});
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1; read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midwalk rst ready", {255'd0, ready}, 256'd0);
    chk("midwalk rst dataout", dataout, 256'd0);
    rst = 1'b0; read = 1'b0;
    wait_ready("ready after midwalk rst");

    // Reset on the same edge as a read: no dout_valid pulse
    wr(1, 1, 32'h80000000, {8'h9E, 248'd0});
    rd("msb byte write", 1, 1, {8'h9E, 248'd0});
    rst = 1'b1; read = 1'b1; rway = 2'd1; rindex = 4'd1;
    @(negedge clk);
    chk("rst beats read", {255'd0, dout_valid}, 256'd0);
    rst = 1'b0; read = 1'b0;
    wait_ready("ready after read rst");
    rd("zero after rst walk", 1, 1, 256'd0);

    @(negedge clk);
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
